// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of the byte-wide puzzle ROM port
// between N_REQ requesters, with optional burst lock and an idle timeout
// that frees an abandoned lock. Responses return 3 cycles after accept.
module rom_port_arbiter #(
    parameter int N_REQ        = 2,
    parameter int N_ADDR_BITS  = 16,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*(N_ADDR_BITS+1)-1:0] req_addr,
    input  logic [N_REQ-1:0]               req_lock,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           rom_en,
    output logic [N_ADDR_BITS:0]           rom_addr,
    input  logic [7:0]                     rom_data,
    input  logic                           rom_valid,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [7:0]                     rsp_data,
    output logic                           rsp_eof
);

    localparam int AW = N_ADDR_BITS + 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {FREE, LOCKED} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    ptr_next;
    logic [CW-1:0]    lock_cnt;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [N_REQ-1:0] tag_issue;
    logic [N_REQ-1:0] tag_data;

    // Grant selection: owner only while locked, else first valid from ptr.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (state == LOCKED) begin
            grant_idx = owner;
            found     = req_valid[owner];
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                idx = 32'(ptr) + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!found && req_valid[PW'(idx)]) begin
                    found     = 1'b1;
                    grant_idx = PW'(idx);
                end
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    assign req_ready = grant;
    assign accept    = found;
    assign sel_addr  = req_addr[32'(grant_idx)*AW +: AW];
    assign ptr_next  = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Arbitration state: round-robin pointer, lock owner and idle timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else if (accept) begin
            ptr      <= ptr_next;
            lock_cnt <= '0;
            if (req_lock[grant_idx]) begin
                state <= LOCKED;
                owner <= grant_idx;
            end else begin
                state <= FREE;
            end
        end else if (state == LOCKED) begin
            if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                state    <= FREE;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    // ROM request register and issuer tag pipeline (issue, data stages).
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            tag_issue <= '0;
            tag_data  <= '0;
        end else begin
            rom_en    <= accept;
            if (accept) rom_addr <= sel_addr;
            tag_issue <= grant;
            tag_data  <= tag_issue;
        end
    end

    // Response register: capture the ROM byte and route it to its issuer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_eof   <= 1'b0;
        end else begin
            rsp_valid <= tag_data;
            if (|tag_data) begin
                rsp_data <= rom_data;
                rsp_eof  <= ~rom_valid;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed stimulus with a scoreboard for ROM issue
// and tagged responses; includes a behavioural ROM of 64 in-range bytes.
module tb_rom_port_arbiter;

    localparam int AW = 17;
    localparam logic [AW-1:0] ROM_SIZE = 17'd64;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [2*AW-1:0] req_addr;
    logic [1:0]      req_lock;
    logic [1:0]      req_ready;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [7:0]      rom_data;
    logic            rom_valid;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_eof;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic mon_on = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       last_eof  = 1'b0;

    typedef struct { logic [1:0] tag; logic [7:0] data; logic eof; int due; } rsp_t;
    typedef struct { logic [AW-1:0] addr; int due; } iss_t;
    rsp_t rsp_q[$];
    iss_t iss_q[$];

    rom_port_arbiter #(.N_REQ(2), .N_ADDR_BITS(16), .LOCK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_lock(req_lock), .req_ready(req_ready), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_eof(rsp_eof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Behavioural ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data  <= rom_byte(rom_addr);
            rom_valid <= (rom_addr < ROM_SIZE);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
                iss_t e;
                e = iss_q.pop_front();
                chk("rom_en", 32'(rom_en), 32'd1);
                chk("rom_addr", 32'(rom_addr), 32'(e.addr));
            end else begin
                chk("rom_en_idle", 32'(rom_en), 32'd0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(r.tag));
                chk("rsp_data", 32'(rsp_data), 32'(r.data));
                chk("rsp_eof", 32'(rsp_eof), 32'(r.eof));
                last_data = r.data;
                last_eof  = r.eof;
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                chk("rsp_data_hold", {23'd0, rsp_eof, rsp_data}, {23'd0, last_eof, last_data});
            end
        end
    end

    // One cycle of stimulus: check the combinational grant, record accepts.
    task automatic step(input logic [1:0] v, input logic [1:0] lk,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [1:0] exp_ready);
        req_valid = v;
        req_lock  = lk;
        req_addr  = {a1, a0};
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        for (int i = 0; i < 2; i++) begin
            if (v[i] && exp_ready[i]) begin
                logic [AW-1:0] a;
                a = (i == 0) ? a0 : a1;
                iss_q.push_back('{addr: a, due: cyc + 1});
                rsp_q.push_back('{tag: 2'(1 << i), data: rom_byte(a),
                                  eof: (a >= ROM_SIZE), due: cyc + 3});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, 2'b00);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        rsp_q.delete();
        iss_q.delete();
        repeat (n) @(posedge clk);
        #1;
        last_data = 8'h00;
        last_eof  = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        @(posedge clk);
        do_reset(2);
        mon_on = 1'b1;

        // Reset state.
        chk("reset_rom_en", 32'(rom_en), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_eof", 32'(rsp_eof), 32'd0);

        // Requester 0 streams 0,1,2 without lock.
        step(2'b01, 2'b00, 17'd0, 17'd0, 2'b01);
        step(2'b01, 2'b00, 17'd1, 17'd0, 2'b01);
        step(2'b01, 2'b00, 17'd2, 17'd0, 2'b01);
        idle(4);

        // Both valid from reset: grants alternate 0,1,0,1.
        do_reset(1);
        step(2'b11, 2'b00, 17'd10, 17'd20, 2'b01);
        step(2'b11, 2'b00, 17'd11, 17'd21, 2'b10);
        step(2'b11, 2'b00, 17'd12, 17'd22, 2'b01);
        step(2'b11, 2'b00, 17'd13, 17'd23, 2'b10);

        // Requester 1 locks, idles 3 cycles while requester 0 waits.
        step(2'b10, 2'b10, 17'd0, 17'd5, 2'b10);
        step(2'b01, 2'b00, 17'd3, 17'd0, 2'b00);
        step(2'b01, 2'b00, 17'd3, 17'd0, 2'b00);
        step(2'b01, 2'b00, 17'd3, 17'd0, 2'b00);
        step(2'b11, 2'b00, 17'd3, 17'd6, 2'b10);
        step(2'b01, 2'b00, 17'd3, 17'd0, 2'b01);

        // Owner 0 locks and abandons: requester 1 granted after 4 idle cycles.
        step(2'b01, 2'b01, 17'd30, 17'd0, 2'b01);
        step(2'b10, 2'b00, 17'd0, 17'd31, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd31, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd31, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd31, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd31, 2'b10);

        // Owner accept in the would-be timeout cycle keeps the lock.
        step(2'b01, 2'b01, 17'd40, 17'd0, 2'b01);
        step(2'b10, 2'b00, 17'd0, 17'd33, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd33, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd33, 2'b00);
        step(2'b11, 2'b01, 17'd41, 17'd33, 2'b01);
        step(2'b10, 2'b00, 17'd0, 17'd33, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd33, 2'b00);
        step(2'b10, 2'b00, 17'd0, 17'd33, 2'b00);
        step(2'b11, 2'b00, 17'd42, 17'd33, 2'b01);
        step(2'b11, 2'b00, 17'd43, 17'd34, 2'b10);

        // Last in-range byte then one past the end.
        step(2'b01, 2'b00, 17'd63, 17'd0, 2'b01);
        step(2'b01, 2'b00, 17'd64, 17'd0, 2'b01);
        idle(4);

        // Reset with two accesses in flight and a lock held by requester 1.
        step(2'b10, 2'b00, 17'd0, 17'd7, 2'b10);
        step(2'b10, 2'b10, 17'd0, 17'd8, 2'b10);
        do_reset(1);
        idle(3);
        step(2'b11, 2'b00, 17'd9, 17'd10, 2'b01);
        step(2'b11, 2'b00, 17'd11, 17'd12, 2'b10);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && (rsp_q.size() > 0 || iss_q.size() > 0); i++) idle(1);
        chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
        chk("drain_iss_q", 32'(iss_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
